digseg_scan: RTL

Time-multiplexing scanner sitting directly downstream of the two-digit seven-segment bus peripheral. It consumes the two decoded segment patterns (`seg0`, `seg1`) that peripheral produces and drives one shared segment bus plus two digit enables, alternating digits at a programmable slot rate with 8-level brightness. New patterns are captured only at frame boundaries, so a bus write never tears a displayed frame.

---
 rtl/digseg_scan.sv | 122 ++++++++++++
 1 files changed

// File: rtl/digseg_scan.sv
// rtl/digseg_scan.sv - two-digit seven-segment scanner with frame-synchronous pattern capture
// Optional feature macro: DIGSEG_SCAN_BLANK_EN (phase 0 of every slot forced blank).
module digseg_scan #(
  parameter int DIV        = 1024,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [2:0] bright_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o,
  output logic       frame_o
);

  localparam int PH_LEN = DIV / 8;
  localparam int SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PH_LEN - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DRIVE,
    ST_BLANK
  } slot_state_t;

  // The slot counter is split into (phase, sub-phase) so the phase never needs a divider.
  logic [SUB_W-1:0] r_sub;
  logic [2:0]       r_phase;
  logic             r_dig;
  logic [6:0]       r_sh0;
  logic [6:0]       r_sh1;
  logic [2:0]       r_bright;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;
  logic             r_frame;

  logic             w_slot_end;
  logic             w_capture;
  logic [6:0]       w_pattern;
  logic [1:0]       w_an_onehot;
  logic [6:0]       w_seg_drive;
  logic [1:0]       w_an_drive;
  slot_state_t      w_state;

  assign w_slot_end  = (r_phase == 3'd7) && (r_sub == SUB_LAST);
  assign w_capture   = w_slot_end && r_dig && en_i;
  assign w_pattern   = r_dig ? r_sh1 : r_sh0;
  assign w_an_onehot = r_dig ? 2'b10 : 2'b01;
  assign w_seg_drive = ACTIVE_LOW ? ~w_pattern : w_pattern;
  assign w_an_drive  = ACTIVE_LOW ? ~w_an_onehot : w_an_onehot;

  always_comb begin
    w_state = ST_OFF;
    if (r_phase <= r_bright) begin
      w_state = ST_DRIVE;
    end
`ifdef DIGSEG_SCAN_BLANK_EN
    if (r_phase == 3'd0) begin
      w_state = ST_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sub    <= '0;
      r_phase  <= 3'd0;
      r_dig    <= 1'b0;
      r_sh0    <= 7'h00;
      r_sh1    <= 7'h00;
      r_bright <= 3'd7;
      r_seg    <= SEG_OFF;
      r_an     <= AN_OFF;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (!en_i) begin
        r_sub   <= '0;
        r_phase <= 3'd0;
        r_dig   <= 1'b0;
        r_seg   <= SEG_OFF;
        r_an    <= AN_OFF;
      end else begin
        if (r_sub == SUB_LAST) begin
          r_sub   <= '0;
          r_phase <= r_phase + 3'd1;
        end else begin
          r_sub <= r_sub + SUB_W'(1);
        end
        if (w_slot_end) begin
          r_dig <= ~r_dig;
        end
        // Shadows load only on the last cycle of digit 1, so a frame is never torn.
        if (w_capture) begin
          r_sh0    <= seg0;
          r_sh1    <= seg1;
          r_bright <= bright_i;
          r_frame  <= 1'b1;
        end
        case (w_state)
          ST_DRIVE: begin
            r_seg <= w_seg_drive;
            r_an  <= w_an_drive;
          end
          default: begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
          end
        endcase
      end
    end
  end

  assign seg_o   = r_seg;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule
